pfc_vsense_sampler: RTL
=======================

Name: pfc_vsense_sampler

Overview:
Upstream sense stage for the PFC controller. It drives a single-channel 24-bit SPI ADC through a 2:1 analog mux, alternating between PFC input voltage and PFC output voltage. Each channel is averaged over 2^AVG_LOG2 conversions and published as the 24-bit PFC_InVSense / PFC_OutVSense words the PFC controller consumes. Scale is 0-200 V full scale, 200/2^24 V per LSB.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period (≥1).
- AVG_LOG2, 2: log2 of samples averaged per channel (0..4).
- SETTLE_CYCLES, 16: clk cycles waited after a mux change before honouring DRDY (≥1).
- OV_LIMIT, 14260633: raw OUT-channel code for 170 V overvoltage trip (PFC_OVP_EN only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- adc_drdy_n  in  1  ADC data-ready, active low, asynchronous to clk.
- adc_miso  in  1  ADC serial data.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  SPI clock, mode 0 (idle low).
- adc_mux  out  1  analog mux select, 0 = PFC input, 1 = PFC output.
- PFC_InVSense  out  24  averaged input-voltage code.
- PFC_OutVSense  out  24  averaged output-voltage code.
- sense_valid  out  1  one-cycle pulse when a full IN+OUT pair has been published.
- ovp_trip  out  1  sticky overvoltage flag; tied 0 when the feature is absent.

Behaviour:
- Reset is async on rst_n low: adc_cs_n=1, adc_sclk=0, adc_mux=0, PFC_InVSense=0, PFC_OutVSense=0, sense_valid=0, ovp_trip=0.
  - Accumulator, sample count, bit count and FSM clear; FSM goes to SETTLE.
  - Reset mid-transfer aborts immediately; the partial word is discarded.
- adc_drdy_n passes through a 2-flop synchronizer and is treated as a level. Minimum DRDY-to-CS latency is 3 clk.
- FSM states:
  - SETTLE: count SETTLE_CYCLES, then go to WAIT_DRDY.
  - WAIT_DRDY: stay until synchronized DRDY is low. No timeout.
  - CS_SETUP: adc_cs_n=0 for CLK_DIV cycles, then go to SHIFT.
  - SHIFT: 24 bits, MSB first.
    - Each bit is CLK_DIV cycles with sclk low, then CLK_DIV cycles with sclk high.
    - adc_miso is captured on the clk edge that drives sclk high.
    - Transfer length is 48*CLK_DIV clk.
  - CS_HOLD: sclk=0, CLK_DIV cycles, then adc_cs_n=1 and go to ACCUM.
  - ACCUM: one cycle; add the sample to the accumulator and increment the count.
    - If count < 2^AVG_LOG2, return to WAIT_DRDY (mux unchanged).
    - Otherwise go to PUBLISH.
  - PUBLISH: one cycle.
    - Write acc >> AVG_LOG2 (truncating) to the register selected by adc_mux.
    - Clear accumulator and count, toggle adc_mux, go to SETTLE.
    - sense_valid pulses in the cycle after PFC_OutVSense is written (mux was 1). No pulse after an IN publish.
- Arithmetic:
  - Accumulator is 24+AVG_LOG2 bits, unsigned, and cannot overflow.
  - An all-ones input averages to 0xFFFFFF.
- Output registers hold their value between publishes. The IN and OUT registers never update in the same cycle.
- DRDY asserting during SETTLE is ignored until SETTLE completes; the level is still seen afterwards.
- First sense_valid after reset follows two full averaging windows plus settles.

Optional Feature:
- Macro: PFC_OVP_EN.
- Defined:
  - In ACCUM with adc_mux=1, any single raw sample ≥ OV_LIMIT sets ovp_trip in the next cycle.
  - ovp_trip stays set until rst_n. It is compared per sample, before averaging.
  - While ovp_trip=1, PUBLISH of the OUT channel writes 0xFFFFFF instead of the average, which forces the downstream controller to zero duty.
- Undefined: ovp_trip is constant 0, OV_LIMIT is unused, and no compare logic is synthesized.

Test Plan:
- Reset check: hold rst_n=0 for 5 clk -> adc_cs_n=1, adc_sclk=0, adc_mux=0, both outputs 0, sense_valid=0; release -> no CS activity for SETTLE_CYCLES+3 clk.
- Single-sample frame: AVG_LOG2=0, CLK_DIV=4, DRDY low, ADC model returns 0xA5A5A5 then 0x3C3C3C -> 24 sclk rising edges per frame, each frame 192 clk; PFC_InVSense=0xA5A5A5, then PFC_OutVSense=0x3C3C3C with one sense_valid pulse.
- Averaging: AVG_LOG2=2, IN samples 100, 200, 300, 401 -> PFC_InVSense=250 (truncated); adc_mux toggles to 1 only after the 4th sample.
- Full scale: 4 IN samples of 0xFFFFFF -> PFC_InVSense=0xFFFFFF, no wrap.
- Reset mid-SHIFT: assert rst_n at bit 10 -> adc_cs_n=1 and adc_sclk=0 combinationally; after release, outputs stay at 0 until a new complete window finishes.
- OVP (PFC_OVP_EN): OUT samples 14260632, then 14260633 -> ovp_trip=0 after the first, 1 after the second; subsequent OUT publishes are 0xFFFFFF; ovp_trip survives until rst_n.

Source files
------------

// File: rtl/pfc_vsense_sampler.sv
// Alternating IN/OUT voltage sampler: drives a 24-bit SPI ADC through a 2:1 mux and publishes
// per-channel averages. Optional overvoltage trip is compiled in with `define PFC_OVP_EN.
module pfc_vsense_sampler #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned OV_LIMIT      = 14260633
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adc_drdy_n,
  input  logic        adc_miso,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_mux,
  output logic [23:0] PFC_InVSense,
  output logic [23:0] PFC_OutVSense,
  output logic        sense_valid,
  output logic        ovp_trip
);

  localparam int unsigned NumAvg = 1 << AVG_LOG2;
  localparam int unsigned AccW   = 24 + AVG_LOG2;
  localparam int unsigned CntW   = AVG_LOG2 + 1;
  localparam int unsigned TmrMax = (SETTLE_CYCLES > CLK_DIV) ? SETTLE_CYCLES : CLK_DIV;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  localparam logic [TmrW-1:0] DivLast    = TmrW'(CLK_DIV - 1);
  localparam logic [TmrW-1:0] SettleLast = TmrW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntLast    = CntW'(NumAvg - 1);

  typedef enum logic [2:0] {
    StSettle,
    StWaitDrdy,
    StCsSetup,
    StShift,
    StCsHold,
    StAccum,
    StPublish
  } state_e;

  state_e            state_q, state_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [4:0]        bit_q, bit_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              mux_q, mux_d;
  logic [23:0]       shift_q, shift_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [23:0]       in_q, in_d;
  logic [23:0]       out_q, out_d;
  logic              valid_q, valid_d;
  logic [1:0]        drdy_sync_q;
  logic [23:0]       avg;
  logic [23:0]       pub_out;

  assign avg = acc_q[AVG_LOG2 +: 24];

  // Synchronizer is held idle during SETTLE so a DRDY that belongs to the previous mux
  // setting cannot be pre-loaded; a level still present afterwards is seen 2 clk later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drdy_sync_q <= 2'b11;
    end else if (state_q == StSettle) begin
      drdy_sync_q <= 2'b11;
    end else begin
      drdy_sync_q <= {drdy_sync_q[0], adc_drdy_n};
    end
  end

`ifdef PFC_OVP_EN
  logic ovp_q;
  logic ovp_hit;

  assign ovp_hit = (state_q == StAccum) && mux_q && (shift_q >= 24'(OV_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovp_q <= 1'b0;
    end else if (ovp_hit) begin
      ovp_q <= 1'b1;
    end
  end

  assign ovp_trip = ovp_q;
  // Full-scale OUT reading forces the downstream loop to zero duty.
  assign pub_out  = ovp_q ? 24'hFFFFFF : avg;
`else
  logic unused_ov_limit;
  assign unused_ov_limit = ^24'(OV_LIMIT);
  assign ovp_trip        = 1'b0;
  assign pub_out         = avg;
`endif

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    mux_d   = mux_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    out_d   = out_q;
    valid_d = 1'b0;

    unique case (state_q)
      StSettle: begin
        if (tmr_q == SettleLast) begin
          tmr_d   = '0;
          state_d = StWaitDrdy;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StWaitDrdy: begin
        if (!drdy_sync_q[1]) begin
          tmr_d   = '0;
          cs_n_d  = 1'b0;
          state_d = StCsSetup;
        end
      end
      StCsSetup: begin
        if (tmr_q == DivLast) begin
          tmr_d   = '0;
          bit_d   = '0;
          state_d = StShift;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StShift: begin
        if (tmr_q == DivLast) begin
          tmr_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // Capture on the edge that raises sclk.
            shift_d = {shift_q[22:0], adc_miso};
          end else if (bit_q == 5'd23) begin
            state_d = StCsHold;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StCsHold: begin
        if (tmr_q == DivLast) begin
          tmr_d   = '0;
          cs_n_d  = 1'b1;
          state_d = StAccum;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StAccum: begin
        acc_d   = acc_q + AccW'(shift_q);
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CntLast) ? StPublish : StWaitDrdy;
      end
      StPublish: begin
        if (mux_q) begin
          out_d   = pub_out;
          valid_d = 1'b1;
        end else begin
          in_d = avg;
        end
        acc_d   = '0;
        cnt_d   = '0;
        tmr_d   = '0;
        mux_d   = ~mux_q;
        state_d = StSettle;
      end
      default: begin
        state_d = StSettle;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StSettle;
      tmr_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mux_q   <= 1'b0;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      in_q    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mux_q   <= mux_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign adc_cs_n      = cs_n_q;
  assign adc_sclk      = sclk_q;
  assign adc_mux       = mux_q;
  assign PFC_InVSense  = in_q;
  assign PFC_OutVSense = out_q;
  assign sense_valid   = valid_q;

endmodule
